// File: rtl/key_seq_if.sv
// key_seq_if: board-side signals of the key sequence detector (button, switch, LED, state code)
interface key_seq_if;
    logic       key;
    logic       sw;
    logic       led;
    logic [3:0] state_count;

    modport master (output key, output sw, input led, input state_count);
    modport slave  (input key, input sw, output led, output state_count);
endinterface

// File: rtl/key_seq_detector.sv
// key_seq_detector: debounced push-button sampler of sw feeding a 1-1-0-1 overlapping Moore detector
module key_seq_detector #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input logic       clk,
    input logic       rst_n,
    key_seq_if.slave  io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] IDLE   = 4'd0;
    localparam logic [3:0] S1     = 4'd1;
    localparam logic [3:0] S11    = 4'd2;
    localparam logic [3:0] S110   = 4'd3;
    localparam logic [3:0] DETECT = 4'd4;

    logic          key_meta_d, key_meta_q, key_sync_d, key_sync_q;
    logic          sw_meta_d, sw_meta_q, sw_sync_d, sw_sync_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [3:0]    state_d, state_q;
    logic          press;

    // Synchronizers and saturating debounce counter; a single high sample restarts the count
    always_comb begin
        key_meta_d = io.key;
        key_sync_d = key_meta_q;
        sw_meta_d  = io.sw;
        sw_sync_d  = sw_meta_q;
        cnt_d      = key_sync_q ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);
        press      = !key_sync_q && cnt_q == CNT_ARM;
    end

    // Next state: only a press pulse advances; stray codes fall back to IDLE unconditionally
    always_comb begin
        case (state_q)
            IDLE:    state_d = press ? (sw_sync_q ? S1 : IDLE) : state_q;
            S1:      state_d = press ? (sw_sync_q ? S11 : IDLE) : state_q;
            S11:     state_d = press ? (sw_sync_q ? S11 : S110) : state_q;
            S110:    state_d = press ? (sw_sync_q ? DETECT : IDLE) : state_q;
            DETECT:  state_d = press ? (sw_sync_q ? S11 : IDLE) : state_q;
            default: state_d = IDLE;
        endcase
    end

    // All state registers, cleared asynchronously; idle key level is released (high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            sw_meta_q  <= 1'b0;
            sw_sync_q  <= 1'b0;
            cnt_q      <= '0;
            state_q    <= IDLE;
        end else begin
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign io.led         = state_q == DETECT;
    assign io.state_count = state_q;
endmodule

// File: tb/tb_key_seq_detector.sv
// tb_key_seq_detector: directed scenarios with a shortened debounce window (one "ms" = one clock)
module tb_key_seq_detector;
    localparam int DC  = 20;
    localparam int LAT = DC + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   chg;
    int   chg_cyc;
    logic [3:0] prev;

    key_seq_if bus ();

    key_seq_detector #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.slave)
    );

    always #10 clk = ~clk;

    task automatic hold(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (bus.state_count !== prev) begin
                chg++;
                chg_cyc = i;
                prev = bus.state_count;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.key = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev = bus.state_count;
    endtask

    task automatic press(input logic b);
        bus.sw = b;
        bus.key = 1'b0;
        chg = 0;
        chg_cyc = 0;
        hold(30);
        bus.key = 1'b1;
        hold(2);
    endtask

    task automatic test_reset();
        bus.key = 1'b1;
        bus.sw = 1'b0;
        rst_n = 1'b0;
        #10;
        total++;
        if (bus.state_count !== 4'd0 || bus.led !== 1'b0) begin
            bad++;
            $display("FAIL reset: state_count=%0d led=%b, want 0 0", bus.state_count, bus.led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev = bus.state_count;
    endtask

    task automatic test_reject();
        do_reset();
        bus.sw = 1'b1;
        bus.key = 1'b0;
        chg = 0;
        hold(10);
        bus.key = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.sw = ~bus.sw;
            hold(1);
        end
        total++;
        if (chg !== 0 || bus.state_count !== 4'd0) begin
            bad++;
            $display("FAIL reject: changes=%0d state_count=%0d, want 0 0", chg, bus.state_count);
        end
    endtask

    task automatic test_single();
        do_reset();
        press(1'b1);
        total++;
        if (chg !== 1 || chg_cyc !== LAT || bus.state_count !== 4'd1) begin
            bad++;
            $display("FAIL single: changes=%0d at=%0d state_count=%0d, want 1 %0d 1", chg, chg_cyc, bus.state_count, LAT);
        end
    endtask

    task automatic run_seq(input string name, input logic [7:0] bits, input logic [31:0] exp_st,
                           input logic [7:0] exp_led, input int n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            press(bits[i]);
            total++;
            if (bus.state_count !== exp_st[4*i +: 4] || bus.led !== exp_led[i] || chg_cyc !== LAT) begin
                bad++;
                $display("FAIL %s press %0d: state_count=%0d led=%b at=%0d, want %0d %b %0d",
                         name, i + 1, bus.state_count, bus.led, chg_cyc, exp_st[4*i +: 4], exp_led[i], LAT);
            end
        end
    endtask

    task automatic test_sequence();
        run_seq("sequence", 8'b1010_1011, 32'h1010_4321, 8'b0000_1000, 8);
    endtask

    task automatic test_overlap();
        run_seq("overlap", 8'b0101_1011, 32'h0432_4321, 8'b0100_1000, 7);
    endtask

    task automatic test_async_clear();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.state_count !== 4'd0 || bus.led !== 1'b0) begin
            bad++;
            $display("FAIL async_clear: state_count=%0d led=%b, want 0 0", bus.state_count, bus.led);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev = bus.state_count;
    endtask

    task automatic test_bounce_hold();
        do_reset();
        bus.sw = 1'b1;
        chg = 0;
        chg_cyc = 0;
        for (int g = 0; g < 8; g++) begin
            bus.key = 1'b0;
            hold(4);
            bus.key = 1'b1;
            hold(1);
        end
        total++;
        if (chg !== 0) begin
            bad++;
            $display("FAIL bounce: changes=%0d during glitches, want 0", chg);
        end
        bus.key = 1'b0;
        hold(LAT + 100);
        total++;
        if (chg !== 1 || chg_cyc !== LAT || bus.state_count !== 4'd1) begin
            bad++;
            $display("FAIL hold: changes=%0d at=%0d state_count=%0d, want 1 %0d 1", chg, chg_cyc, bus.state_count, LAT);
        end
        bus.key = 1'b1;
        hold(2);
    endtask

    task automatic test_reset_mid_press();
        do_reset();
        bus.sw = 1'b1;
        bus.key = 1'b0;
        hold(15);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev = bus.state_count;
        chg = 0;
        chg_cyc = 0;
        hold(LAT + 5);
        total++;
        if (chg !== 1 || chg_cyc !== LAT || bus.state_count !== 4'd1) begin
            bad++;
            $display("FAIL reset_mid_press: changes=%0d at=%0d state_count=%0d, want 1 %0d 1", chg, chg_cyc, bus.state_count, LAT);
        end
        bus.key = 1'b1;
        hold(2);
    endtask

    initial begin
        test_reset();
        test_reject();
        test_single();
        test_sequence();
        test_overlap();
        test_async_clear();
        test_bounce_hold();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_seq_detector.md
Name: key_seq_detector

Overview:
- Single-clock block that debounces an active-low push-button `key` and samples switch `sw` once per accepted press.
- The sampled bit drives a Moore FSM that detects the serial pattern 1-1-0-1, with overlap allowed.
- Outputs are a detection LED and the current FSM state code, for board-level lab/demo use at 50 MHz.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive synchronized-low clock cycles (20 ms at 50 MHz) needed to accept one press.

Ports:
- clk  input  1  system clock, 50 MHz nominal, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- key  input  1  raw push-button, active-low (0 = pressed), asynchronous, may bounce.
- sw  input  1  raw slide switch; the serial data bit sampled at each accepted press.
- led  output  1  high while FSM is in DETECT state.
- state_count  output  4  current FSM state code, zero-extended.

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low; all flops clear immediately on assertion.
- Reset values:
  - led = 0, state_count = 0.
  - Debounce counter = 0, press flag = 0.
  - Synchronizer flops: key path = 1, sw path = 0.
- Synchronization: `key` and `sw` each pass through a 2-flop synchronizer before any use.
- Debounce counter:
  - Width: ceil(log2(DEBOUNCE_CYCLES+1)) bits.
  - Synchronized key = 1: counter clears to 0 in the same cycle.
  - Synchronized key = 0: counter increments and saturates at DEBOUNCE_CYCLES.
- Press pulse:
  - Exactly one cycle, generated in the cycle the counter transitions DEBOUNCE_CYCLES-1 -> DEBOUNCE_CYCLES.
  - A held press gives only one pulse.
  - Any high glitch during a press restarts the count.
  - Re-arming needs only one synchronized-high cycle; no release debounce. A 2 ms release must be accepted.
- Sampling: on the pulse cycle, the synchronized sw value is the FSM input bit. The FSM advances on the clock edge ending the pulse cycle, so state_count/led change one cycle after the pulse.
- FSM (Moore; code = state_count):
  - IDLE = 0: bit 1 -> S1; bit 0 -> IDLE.
  - S1 = 1: bit 1 -> S11; bit 0 -> IDLE.
  - S11 = 2: bit 1 -> S11; bit 0 -> S110.
  - S110 = 3: bit 1 -> DETECT; bit 0 -> IDLE.
  - DETECT = 4: bit 1 -> S11 (overlap); bit 0 -> IDLE.
  - Codes 5..15 unreachable; if entered, go to IDLE on the next clock.
- led = 1 only in DETECT. It stays high until the next accepted press; no timeout.
- Without a press pulse, the state holds regardless of sw changes.
- Reset mid-press: counter clears. The key must then stay low a full DEBOUNCE_CYCLES after reset release to be accepted.
- Total latency: key falling edge -> state update = 2 sync cycles + DEBOUNCE_CYCLES + 1 cycle (±1 for async input alignment).

Test Plan:
- Reset: rst_n low for 10 ns with key=1 -> led=0, state_count=0. Asynchronous clear is seen mid-cycle.
- Debounce reject: key low 10 ms, then high, with sw=1 -> no pulse, state_count remains 0.
- Single press: sw=1, key low 30 ms, then high 2 ms -> state_count 0->1 about 20.00 ms after the falling edge; exactly one transition.
- Full sequence, 8 presses (each key low 30 ms, high 2 ms) with sw = 1,1,0,1,0,1,0,1:
  - state_count after each press = 1,2,3,4,0,1,0,1.
  - led high only between the 4th and 5th accepted presses; final led=0, state_count=1.
- Overlap: sw = 1,1,0,1,1,0,1 -> state_count 1,2,3,4,2,3,4; led asserted after the 4th and 7th presses.
- Bounce and hold:
  - Key low with 1 µs high glitches every 5 ms for 40 ms -> no pulse until 20 ms after the last glitch.
  - Then hold low an extra 100 ms -> exactly one pulse.
